// File: rtl/decoder_sel_arbiter.sv
// Round-robin arbiter that drives the 2-bit select of a downstream 2-to-4 decoder.
// Grants are held for a fixed burst and separated by break-before-make gap cycles.
module decoder_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       grant_release,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       grant_start,
  output logic       busy
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last;
  logic             found;
  logic [1:0]       winner;
  logic [1:0]       idx;

  // The search starts just past the last winner, so that channel ranks lowest.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = last + 2'(i + 1);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      cnt         <= '0;
      last        <= 2'd3;
      sel         <= 2'd0;
      sel_valid   <= 1'b0;
      grant_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (found) begin
            sel         <= winner;
            last        <= winner;
            sel_valid   <= 1'b1;
            grant_start <= 1'b1;
            busy        <= 1'b1;
            cnt         <= HOLD_LOAD;
            state       <= GRANT;
          end
        end
        GRANT: begin
          grant_start <= 1'b0;
          if (cnt == '0 || grant_release) begin
            sel_valid <= 1'b0;
            cnt       <= GAP_LOAD;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              busy  <= 1'b0;
              state <= ARB;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          // sel is left untouched so the decoder input stays stable through the gap.
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= ARB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_sel_arbiter.sv
// Bench for decoder_sel_arbiter: default instance plus a zero-gap instance, both
// checked every cycle against a grant-schedule model and by directed scenarios.
module tb_decoder_sel_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       grant_release = 1'b0;

  logic [1:0] sel1, sel0;
  logic       sv1, sv0, gs1, gs0, busy1, busy0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decoder_sel_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_release(grant_release),
    .sel(sel1), .sel_valid(sv1), .grant_start(gs1), .busy(busy1)
  );

  decoder_sel_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_release(grant_release),
    .sel(sel0), .sel_valid(sv0), .grant_start(gs0), .busy(busy0)
  );

  // Model phases: 0 idle/arbitrating, 1 granting (age = cycles into grant), 2 gap.
  typedef struct {
    int phase;
    int age;
    int gleft;
    int last;
    int sel;
    int sv;
    int gs;
    int busy;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.phase = 0; m.age = 0; m.gleft = 0; m.last = 3;
    m.sel = 0; m.sv = 0; m.gs = 0; m.busy = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic [3:0] rq, logic rl, int gap);
    model_t n = m;
    bit hit = 0;
    if (m.phase == 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c = (m.last + k) % 4;
        if (!hit && rq[c]) begin
          hit = 1;
          n.sel = c; n.last = c; n.sv = 1; n.gs = 1; n.busy = 1;
          n.phase = 1; n.age = 0;
        end
      end
    end else if (m.phase == 1) begin
      n.gs = 0;
      if (m.age == HOLD - 1 || rl) begin
        n.sv = 0;
        if (gap > 0) begin
          n.phase = 2; n.gleft = gap;
        end else begin
          n.phase = 0; n.busy = 0;
        end
      end else begin
        n.age = m.age + 1;
      end
    end else begin
      n.gleft = m.gleft - 1;
      if (n.gleft == 0) begin
        n.phase = 0; n.busy = 0;
      end
    end
    return n;
  endfunction

  model_t m1 = model_reset();
  model_t m0 = model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = model_reset();
      m0 = model_reset();
    end else begin
      m1 = model_step(m1, req, grant_release, 1);
      m0 = model_step(m0, req, grant_release, 0);
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int  prev_sel1 = 0, prev_sel0 = 0;
  bit  prev_sv1 = 0, prev_sv0 = 0;

  always @(negedge clk) begin
    check_output("m1_sel", int'(sel1), m1.sel);
    check_output("m1_sel_valid", int'(sv1), m1.sv);
    check_output("m1_grant_start", int'(gs1), m1.gs);
    check_output("m1_busy", int'(busy1), m1.busy);
    check_output("m0_sel", int'(sel0), m0.sel);
    check_output("m0_sel_valid", int'(sv0), m0.sv);
    check_output("m0_grant_start", int'(gs0), m0.gs);
    check_output("m0_busy", int'(busy0), m0.busy);
    if ((sv1 || gs1) && !busy1) check_output("inv1_busy", int'(busy1), 1);
    if ((sv0 || gs0) && !busy0) check_output("inv0_busy", int'(busy0), 1);
    if (prev_sv1 && sv1) check_output("inv1_sel_stable", int'(sel1), prev_sel1);
    if (prev_sv0 && sv0) check_output("inv0_sel_stable", int'(sel0), prev_sel0);
    prev_sv1 = sv1; prev_sel1 = int'(sel1);
    prev_sv0 = sv0; prev_sel0 = int'(sel0);
  end

  function automatic logic sv_of(input int which);
    return (which == 0) ? sv0 : sv1;
  endfunction

  function automatic logic gs_of(input int which);
    return (which == 0) ? gs0 : gs1;
  endfunction

  task automatic apply_stimulus(input logic [3:0] rq, input logic rl);
    @(negedge clk);
    req = rq;
    grant_release = rl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 4'b0000;
    grant_release = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts consecutive sampled cycles with sel_valid at the given level.
  task automatic measure_run(input int which, input logic level, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (sv_of(which) != level) return;
      n++;
      @(negedge clk);
    end
    check_output("run_timeout", 0, 1);
  endtask

  task automatic wait_grant(input int which, output int waited);
    waited = 0;
    for (int i = 0; i < 60; i++) begin
      if (gs_of(which)) return;
      waited++;
      @(negedge clk);
    end
    check_output("grant_timeout", 0, 1);
  endtask

  int n;
  int w;

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] idle with no requests");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("t1_sel", int'(sel1), 0);
      check_output("t1_sel_valid", int'(sv1), 0);
      check_output("t1_busy", int'(busy1), 0);
    end

    $display("[TB] single requester channel 2");
    apply_stimulus(4'b0100, 1'b0);
    @(negedge clk);
    check_output("t2_sel", int'(sel1), 2);
    check_output("t2_grant_start", int'(gs1), 1);
    measure_run(1, 1'b1, n);
    check_output("t2_hold_len", n, 4);
    measure_run(1, 1'b0, n);
    check_output("t2_low_len", n, 2);
    check_output("t2_regrant_sel", int'(sel1), 2);
    check_output("t2_regrant_start", int'(gs1), 1);

    $display("[TB] all four requesting");
    do_reset();
    apply_stimulus(4'b1111, 1'b0);
    for (int g = 0; g < 5; g++) begin
      wait_grant(1, w);
      check_output("t3_order", int'(sel1), g % 4);
      if (g > 0) check_output("t3_period", w + 1, 6);
      @(negedge clk);
    end

    $display("[TB] early release");
    do_reset();
    apply_stimulus(4'b0010, 1'b0);
    wait_grant(1, w);
    check_output("t4_sel", int'(sel1), 1);
    @(negedge clk);
    grant_release = 1'b1;
    check_output("t4_sv_cycle1", int'(sv1), 1);
    @(negedge clk);
    grant_release = 1'b0;
    check_output("t4_sv_cycle2", int'(sv1), 0);
    check_output("t4_busy_gap", int'(busy1), 1);
    check_output("t4_sv0_cycle2", int'(sv0), 0);
    check_output("t4_busy0_nogap", int'(busy0), 0);

    $display("[TB] asynchronous reset mid-grant");
    do_reset();
    apply_stimulus(4'b1000, 1'b0);
    wait_grant(1, w);
    @(negedge clk);
    @(negedge clk);
    check_output("t5_sel_before", int'(sel1), 3);
    check_output("t5_sv_before", int'(sv1), 1);
    #1 rst_n = 1'b0;
    #1;
    check_output("t5_sel_clear", int'(sel1), 0);
    check_output("t5_sv_clear", int'(sv1), 0);
    check_output("t5_busy_clear", int'(busy1), 0);
    check_output("t5_sv0_clear", int'(sv0), 0);
    check_output("t5_busy0_clear", int'(busy0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1001;
    wait_grant(1, w);
    check_output("t5_first_after_reset", int'(sel1), 0);
    check_output("t5_first_after_reset0", int'(sel0), 0);

    $display("[TB] zero-gap back-to-back grants");
    do_reset();
    apply_stimulus(4'b0011, 1'b0);
    wait_grant(0, w);
    check_output("t6_first", int'(sel0), 0);
    measure_run(0, 1'b1, n);
    check_output("t6_hold_len", n, 4);
    measure_run(0, 1'b0, n);
    check_output("t6_low_len", n, 1);
    check_output("t6_second", int'(sel0), 1);
    check_output("t6_second_start", int'(gs0), 1);

    apply_stimulus(4'b0000, 1'b0);
    repeat (8) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
